// File: rtl/dot_matrix_scan_capture.sv
// Receive side of the 8x16 dot-matrix scan bus: settles each strobed line, rebuilds frames in a
// working buffer and commits complete frames to a second buffer behind a registered read port.
module dot_matrix_scan_capture #(
    parameter int ROWS    = 8,
    parameter int COLS    = 16,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] scan_row,
    input  logic [COLS-1:0] scan_col,
    input  logic [2:0]      rd_addr,
    input  logic            clr_err,
    output logic [COLS-1:0] rd_data,
    output logic            frame_valid,
    output logic [15:0]     frame_cnt,
    output logic            err_onehot,
    output logic            err_seq,
    output logic            stall,
    output logic [1:0]      dbg_state
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_FILL   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t          r_state;
    logic [ROWS-1:0] r_row, r_prev_row;
    logic [COLS-1:0] r_col, r_prev_col;
    logic [SW-1:0]   r_cnt;
    logic            r_done;
    logic [IW-1:0]   r_exp;
    logic [COLS-1:0] r_work [ROWS];
    logic [COLS-1:0] r_comm [ROWS];
    logic [COLS-1:0] r_rd;
    logic            r_fv;
    logic [15:0]     r_fcnt;
    logic            r_err_oh, r_err_seq;
    logic [TW-1:0]   r_tcnt;
    logic            r_stall;

    logic [ROWS-1:0] w_low;
    logic            w_blank, w_multi, w_same, w_done, w_accept, w_tsat, w_seq;
    logic [SW-1:0]   w_cnt;
    logic [TW-1:0]   w_tnext;
    logic [IW-1:0]   w_idx;

    assign w_low   = ~r_row;
    assign w_blank = (w_low == '0);
    assign w_multi = ((w_low & (w_low - ROWS'(1))) != '0);
    assign w_same  = (r_row == r_prev_row) && (r_col == r_prev_col);
    assign w_cnt   = !w_same ? SW'(1) :
                     ((r_cnt == SW'(SETTLE)) ? r_cnt : r_cnt + SW'(1));
    // A line is taken once per row visit; a column change inside the same row does not re-arm it.
    assign w_done   = r_done && (r_row == r_prev_row);
    assign w_accept = !w_blank && !w_multi && (w_cnt == SW'(SETTLE)) && !w_done;
    assign w_tsat   = (r_tcnt == TW'(TIMEOUT));
    assign w_tnext  = w_accept ? '0 : (w_tsat ? r_tcnt : r_tcnt + TW'(1));
    assign w_seq    = w_accept && (r_state == S_FILL) && (w_idx != r_exp);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (w_low[i]) w_idx = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row      <= '1;
            r_prev_row <= '1;
            r_col      <= '0;
            r_prev_col <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_tcnt     <= '0;
            r_stall    <= 1'b0;
            r_err_oh   <= 1'b0;
            r_err_seq  <= 1'b0;
            r_rd       <= '0;
        end else begin
            r_row      <= scan_row;
            r_col      <= scan_col;
            r_prev_row <= r_row;
            r_prev_col <= r_col;
            r_cnt      <= w_cnt;
            r_done     <= w_accept | w_done;
            r_tcnt     <= w_tnext;
            r_stall    <= (w_tnext == TW'(TIMEOUT));
            r_err_oh   <= w_multi | (r_err_oh & ~clr_err);
            r_err_seq  <= w_seq | (r_err_seq & ~clr_err);
            r_rd       <= (32'(rd_addr) < ROWS) ? r_comm[rd_addr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_SYNC;
            r_exp   <= '0;
            r_fv    <= 1'b0;
            r_fcnt  <= '0;
            for (int i = 0; i < ROWS; i++) begin
                r_work[i] <= '0;
                r_comm[i] <= '0;
            end
        end else begin
            r_fv <= 1'b0;
            if (r_state == S_COMMIT) begin
                r_comm  <= r_work;
                r_fv    <= 1'b1;
                r_fcnt  <= r_fcnt + 16'd1;
                r_state <= S_SYNC;
            end else if (w_multi) begin
                r_state <= S_SYNC;
            end else if (w_accept) begin
                if (r_state == S_FILL && w_idx == r_exp) begin
                    r_work[w_idx] <= r_col;
                    if (r_exp == '0) r_state <= S_COMMIT;
                    else r_exp <= r_exp - IW'(1);
                end else if (w_idx == IW'(ROWS - 1)) begin
                    // Top row always (re)starts a frame, including after an order violation.
                    r_work[w_idx] <= r_col;
                    r_exp         <= IW'(ROWS - 2);
                    r_state       <= S_FILL;
                end else begin
                    r_state <= S_SYNC;
                end
            end else if (w_tsat) begin
                r_state <= S_SYNC;
            end
        end
    end

    assign rd_data     = r_rd;
    assign frame_valid = r_fv;
    assign frame_cnt   = r_fcnt;
    assign err_onehot  = r_err_oh;
    assign err_seq     = r_err_seq;
    assign stall       = r_stall;
    assign dbg_state   = r_state;
endmodule
